// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state type and bit-timing constants for the TX and RX paths.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

    localparam int unsigned DATA_BITS          = 8;
    localparam int unsigned CLKS_PER_BIT_57600 = 868;
    localparam int unsigned HALF_BIT_57600     = 434;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_TX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } uart_state_t;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and pulses rollover on the last count.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_57600
) (
    input  logic clk,
    input  logic clear,
    output logic rollover
);

    localparam int unsigned W = $clog2(CLKS_PER_BIT);
    localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (clear || rollover) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

    assign rollover = (cnt == LAST);

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin UART transmit scheduler sharing one TX line among NUM_REQ byte requesters.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 2,
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_57600
) (
    input  logic                 CLOCK_50,
    input  logic                 s_reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] data,
    output logic [NUM_REQ-1:0]   ack,
    output logic [2:0]           grant_id,
    output logic                 busy,
    output logic                 done,
    output logic                 tx
);

    uart_state_t state_q, next_state;

    logic [2:0] ptr_q;
    logic [7:0] shreg_q;
    logic [2:0] bit_cnt_q;
    logic       roll;
    logic       timer_clear;
    logic       take;
    logic       found;
    logic [2:0] win;
    logic [7:0] win_byte;
    logic [3:0] pos;
`ifdef UART_TX_PARITY_EN
    logic       par_q;
`endif

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk     (CLOCK_50),
        .clear   (timer_clear),
        .rollover(roll)
    );

    // First pending requester at or after the pointer, scanning by offset.
    always_comb begin
        found    = 1'b0;
        win      = '0;
        win_byte = '0;
        pos      = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            pos = 4'(ptr_q) + 4'(k);
            if (pos >= 4'(NUM_REQ)) begin
                pos = pos - 4'(NUM_REQ);
            end
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (!found && req[i] && (pos == 4'(i))) begin
                    found    = 1'b1;
                    win      = 3'(i);
                    win_byte = data[8*i +: 8];
                end
            end
        end
    end

    assign take = (state_q == ST_IDLE) && found;

    always_comb begin
        next_state = state_q;
        ack        = '0;
        case (state_q)
            ST_IDLE: begin
                if (take) begin
                    next_state = ST_START;
                    for (int unsigned i = 0; i < NUM_REQ; i++) begin
                        ack[i] = (win == 3'(i));
                    end
                end
            end
            ST_START: begin
                if (roll) next_state = ST_DATA;
            end
            ST_DATA: begin
                if (roll && (bit_cnt_q == 3'(DATA_BITS - 1))) begin
`ifdef UART_TX_PARITY_EN
                    next_state = ST_PARITY;
`else
                    next_state = ST_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (roll) next_state = ST_STOP;
            end
`endif
            ST_STOP: begin
                if (roll) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // The timer is held at zero in IDLE so the start bit gets a full period.
    assign timer_clear = s_reset || (state_q == ST_IDLE) || (next_state != state_q);

    always_ff @(posedge CLOCK_50) begin
        if (s_reset) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            grant_id  <= '0;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
`ifdef UART_TX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q <= next_state;
            if (take) begin
                shreg_q   <= win_byte;
                grant_id  <= win;
                bit_cnt_q <= '0;
                ptr_q     <= (win == 3'(NUM_REQ - 1)) ? 3'd0 : win + 3'd1;
`ifdef UART_TX_PARITY_EN
                par_q     <= ^win_byte;
`endif
            end else if ((state_q == ST_DATA) && roll) begin
                shreg_q   <= {1'b0, shreg_q[7:1]};
                bit_cnt_q <= bit_cnt_q + 3'd1;
            end
        end
    end

    // Line and done are registered from the state, so both trail the FSM by one cycle.
    always_ff @(posedge CLOCK_50) begin
        if (s_reset) begin
            tx   <= 1'b1;
            done <= 1'b0;
        end else begin
            done <= (state_q == ST_STOP) && roll;
            case (state_q)
                ST_START:  tx <= 1'b0;
                ST_DATA:   tx <= shreg_q[0];
`ifdef UART_TX_PARITY_EN
                ST_PARITY: tx <= par_q;
`endif
                default:   tx <= 1'b1;
            endcase
        end
    end

    assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched (NUM_REQ=2, CLKS_PER_BIT=4), directed plus random frames.
module tb_uart_tx_sched;

    localparam int C = 4;
    localparam int N = 2;
`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int FL = FB * C;

    logic        CLOCK_50 = 1'b0;
    logic        s_reset  = 1'b1;
    logic [1:0]  req      = '0;
    logic [15:0] data     = '0;
    logic [1:0]  ack;
    logic [2:0]  grant_id;
    logic        busy;
    logic        done;
    logic        tx;

    int n_tests = 0;
    int n_fail  = 0;
    int ptr     = 0;

    uart_tx_sched #(
        .NUM_REQ     (N),
        .CLKS_PER_BIT(C)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .s_reset (s_reset),
        .req     (req),
        .data    (data),
        .ack     (ack),
        .grant_id(grant_id),
        .busy    (busy),
        .done    (done),
        .tx      (tx)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    function automatic int winner(input logic [1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            int i;
            i = (p + k) % N;
            if (r[i]) return i;
        end
        return 0;
    endfunction

    // Serial frame as the line should show it: start, 8 data LSB-first, [parity], stop.
    function automatic logic frame_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
`ifdef UART_TX_PARITY_EN
        if (idx == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Entered on the negedge of an IDLE cycle with a request pending; returns on
    // the negedge of the IDLE cycle that follows the frame.
    task automatic check_frame(input bit keep, input int mid_k, input logic [1:0] mid_req,
                               input logic [15:0] mid_data, input bit pulse);
        int         id;
        logic [7:0] b;
        id = winner(req, ptr);
        b  = (id == 0) ? data[7:0] : data[15:8];
        chk("ack_grant", 16'(ack), 16'(2'b01 << id));
        chk("busy_at_ack", 16'(busy), 16'd0);
        ptr = (id + 1) % N;
        for (int j = 0; j <= FL; j++) begin
            @(posedge CLOCK_50);
            #1;
            if (j == 0 && !keep) req[id] = 1'b0;
            if (mid_k > 0 && j == mid_k) begin
                req  = mid_req;
                data = mid_data;
            end
            if (pulse && j == mid_k + 1) req = '0;
            @(negedge CLOCK_50);
            if (j == 0) begin
                chk("tx_after_capture", 16'(tx), 16'd1);
                chk("busy_rise", 16'(busy), 16'd1);
                chk("done_early", 16'(done), 16'd0);
            end else begin
                chk("tx_bit", 16'(tx), 16'(frame_bit(b, (j - 1) / C)));
                chk("done", 16'(done), 16'(j == FL));
                chk("busy", 16'(busy), 16'(j < FL));
            end
            chk("grant_id", 16'(grant_id), 16'(id));
            if (j < FL) chk("ack_in_frame", 16'(ack), 16'd0);
        end
    endtask

    task automatic idle_check(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(negedge CLOCK_50);
            chk("idle_tx", 16'(tx), 16'd1);
            chk("idle_busy", 16'(busy), 16'd0);
            chk("idle_done", 16'(done), 16'd0);
            chk("idle_ack", 16'(ack), 16'd0);
        end
    endtask

    initial begin
        repeat (3) @(negedge CLOCK_50);
        chk("rst_tx", 16'(tx), 16'd1);
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_ack", 16'(ack), 16'd0);
        chk("rst_done", 16'(done), 16'd0);
        chk("rst_grant", 16'(grant_id), 16'd0);
        s_reset = 1'b0;
        idle_check(2);

        // Single requests: alternating pattern and the two parity-distinguishing bytes.
        data = 16'h0055; req = 2'b01; #1;
        check_frame(1'b0, 0, '0, '0, 1'b0);
        chk("ack_after_single", 16'(ack), 16'd0);
        idle_check(3);
        data = 16'h0007; req = 2'b01; #1;
        check_frame(1'b0, 0, '0, '0, 1'b0);
        idle_check(1);
        data = 16'h0003; req = 2'b01; #1;
        check_frame(1'b0, 0, '0, '0, 1'b0);
        idle_check(1);

        // req[1] raised mid-frame waits for the frame to finish.
        data = 16'h5AC3; req = 2'b01; #1;
        check_frame(1'b0, 20, 2'b10, 16'h5AC3, 1'b0);
        check_frame(1'b0, 0, '0, '0, 1'b0);
        idle_check(2);

        // One-cycle request while busy is lost.
        data = 16'h00E7; req = 2'b01; #1;
        check_frame(1'b0, 10, 2'b10, 16'h3CE7, 1'b1);
        idle_check(2 * FL);

        // Reset during DATA bit 3 aborts without done and clears the pointer.
        data = 16'h00F0; req = 2'b01; #1;
        chk("ack_pre_abort", 16'(ack), 16'd1);
        ptr = 1;
        @(posedge CLOCK_50); #1;
        req = '0;
        repeat (17) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        chk("busy_pre_abort", 16'(busy), 16'd1);
        s_reset = 1'b1;
        @(negedge CLOCK_50);
        chk("abort_tx", 16'(tx), 16'd1);
        chk("abort_busy", 16'(busy), 16'd0);
        chk("abort_done", 16'(done), 16'd0);
        s_reset = 1'b0;
        ptr = 0;
        idle_check(50);

        // Both held: strict alternation starting from requester 0, 1-cycle gaps.
        data = 16'hB2A1; req = 2'b11; #1;
        check_frame(1'b1, 0, '0, '0, 1'b0);
        check_frame(1'b1, 0, '0, '0, 1'b0);
        check_frame(1'b1, 0, '0, '0, 1'b0);
        check_frame(1'b0, 5, 2'b00, 16'hB2A1, 1'b0);
        idle_check(3);

        // Random request masks and bytes, re-drawn mid-frame.
        data = 16'($urandom); req = 2'($urandom_range(1, 3)); #1;
        for (int it = 0; it < 12; it++) begin
            check_frame(1'b0, int'($urandom_range(2, 30)),
                        (it < 11) ? 2'($urandom_range(1, 3)) : 2'b00,
                        16'($urandom), 1'b0);
        end
        idle_check(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Round-robin transmit scheduler that shares one UART serial output between `NUM_REQ` byte requesters. It arbitrates pending requests, captures the winning byte with a one-cycle acknowledge, and sequences the start, data, optional parity and stop bits at a fixed baud period on its own bit-timer. It sits between on-chip byte producers and the GPIO TX pin, and is the transmit-side counterpart to the existing receive path.

## Interface
Parameters:
- `NUM_REQ`, default 2: number of requesters, valid range 2..8.
- `CLKS_PER_BIT`, default 868: clock cycles per serial bit (50 MHz / 57600 baud); must be ≥ 2.

Ports:
- `CLOCK_50`  in  1: sole clock; all logic on its rising edge.
- `s_reset`  in  1: reset, synchronous and active-high.
- `req`  in  NUM_REQ: per-requester send request, level.
- `data`  in  8*NUM_REQ: byte for requester i is `data[8i+7:8i]`.
- `ack`  out  NUM_REQ: one-hot, single-cycle pulse; the byte is captured on this cycle.
- `grant_id`  out  3: index of the requester owning the current or last frame.
- `busy`  out  1: high from capture through the end of the stop bit.
- `done`  out  1: single-cycle pulse on the last cycle of the stop bit.
- `tx`  out  1: serial line, idles high.

## Operation
- States: IDLE, START, DATA, PARITY (macro only), STOP.
- IDLE: if any `req[i]` is high, pick the first set bit at or after the round-robin pointer (wrap at NUM_REQ). On that cycle `ack[i]`=1, the byte is latched into the shift register, `grant_id` is set to i, and the next state is START. The pointer becomes (i+1) mod NUM_REQ.
- START: `tx`=0 for CLKS_PER_BIT cycles, then DATA.
- DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles. A 3-bit counter advances on each bit-timer rollover; after bit 7 the next state is PARITY or STOP.
- STOP: `tx`=1 for CLKS_PER_BIT cycles. `done` is pulsed on the final cycle, then IDLE.
- The bit timer is cleared on every state entry and counts 0..CLKS_PER_BIT-1 (width $clog2(CLKS_PER_BIT)); rollover ends the current bit.
- Handshake: a requester holds `req` and `data` stable until it sees `ack`. A `req` that is deasserted before grant is dropped with no effect. A `req` still high after `ack` is treated as a new request for the next frame.
- Inputs are ignored outside IDLE; there is no queueing.
- Reset values: `tx`=1, `busy`=0, `ack`=0, `done`=0, `grant_id`=0, pointer=0, state IDLE.
- Reset mid-frame aborts the frame: `tx`=1 from the next edge, and no `done` is issued.

## Timing
- Capture to `tx` falling edge: 1 cycle. Capture is edge N; `tx`=0 from edge N+1.
- Frame length: 10×CLKS_PER_BIT cycles, or 11× with parity.
- `busy` rises on the edge after capture and falls with the return to IDLE.
- Back-to-back frames: IDLE lasts exactly 1 cycle between frames when a request is pending, so the minimum inter-frame gap is 1 clock of idle-high.
- Simultaneous requests in IDLE are resolved by the pointer only. Two requesters that both hold `req` continuously alternate strictly.

## Configuration
- `UART_TX_PARITY_EN` defined: the PARITY state is inserted after DATA. It drives even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
- `UART_TX_PARITY_EN` undefined: the PARITY state and its logic are absent, and DATA goes straight to STOP.

## Structure
- Shared package `uart_pkg` holds:
  - the state enum type;
  - `DATA_BITS`=8;
  - the default `CLKS_PER_BIT_57600`=868;
  - the half-bit constant 434, reused by the receive side.
- One natural sub-module: `uart_bit_timer`, a counter with synchronous clear, `CLKS_PER_BIT` parameter and one-cycle rollover output.
- Arbiter, shift register and FSM stay in the top module.

## Test plan
- Single request, req[0] with data 0x55, CLKS_PER_BIT=4 → ack[0] for 1 cycle; `tx` reads 0,1,0,1,0,1,0,1,0,1 at 4 cycles per bit; `done` at cycle 40 after capture.
- req[0] and req[1] asserted together from reset, bytes 0xA1/0xB2, both held → grants in order 0,1,0,1; `grant_id` alternates; each inter-frame gap is exactly 1 cycle.
- req[1] raised mid-frame of requester 0 → no ack until the cycle after `done`, then ack[1].
- `s_reset` asserted during DATA bit 3 → next cycle `tx`=1, `busy`=0, no `done`; a subsequent request starts a clean frame with pointer=0.
- Parity build, byte 0x07 → parity bit 1 before the stop bit; byte 0x03 → parity bit 0; frame is 44 cycles at CLKS_PER_BIT=4.
- req pulsed for 1 cycle while busy → never acknowledged, and no spurious frame follows.
